// File: rtl/sdram_arbiter.sv
// ---------------------------------------------------------------------------
// sdram_arbiter
//   Shares one Avalon-MM SDRAM controller slave between two masters:
//   m0 (median-filter pixel DMA) and m1 (Nios II data bridge).
//   - Round-robin grant, computed combinationally, no bubble between
//     accepted commands.
//   - A command stalled by the controller stays locked to its master until
//     it is accepted.
//   - A FIFO of 1-bit master tags (one per outstanding read) routes the
//     pipelined read responses back to the issuing master.
//
// Ports
//   clk_clk, reset_reset          : clock, synchronous active-high reset
//   mX_address/read/write/
//     writedata/byteenable        : master X command inputs
//   mX_waitrequest                : master X stall
//   mX_readdata/readdatavalid     : master X read response
//   s_address/read/write/
//     writedata/byteenable        : command to the SDRAM controller
//   s_waitrequest                 : controller stall
//   s_readdata/readdatavalid      : controller read response
//   pend_count                    : outstanding reads held in the tag FIFO
//   rsp_error                     : sticky, response seen with no read pending
//
// Handshake: a command is transferred on a rising edge where s_read or
// s_write is 1 and s_waitrequest is 0. A master's command is transferred on
// an edge where its read/write is 1 and its waitrequest is 0. Read responses
// carry no backpressure.
// ---------------------------------------------------------------------------
module sdram_arbiter #(
    parameter int ADDR_W   = 24,
    parameter int DATA_W   = 16,
    parameter int MAX_PEND = 8
) (
    input  logic                         clk_clk,
    input  logic                         reset_reset,

    input  logic [ADDR_W-1:0]            m0_address,
    input  logic                         m0_read,
    input  logic                         m0_write,
    input  logic [DATA_W-1:0]            m0_writedata,
    input  logic [DATA_W/8-1:0]          m0_byteenable,
    output logic                         m0_waitrequest,
    output logic [DATA_W-1:0]            m0_readdata,
    output logic                         m0_readdatavalid,

    input  logic [ADDR_W-1:0]            m1_address,
    input  logic                         m1_read,
    input  logic                         m1_write,
    input  logic [DATA_W-1:0]            m1_writedata,
    input  logic [DATA_W/8-1:0]          m1_byteenable,
    output logic                         m1_waitrequest,
    output logic [DATA_W-1:0]            m1_readdata,
    output logic                         m1_readdatavalid,

    output logic [ADDR_W-1:0]            s_address,
    output logic                         s_read,
    output logic                         s_write,
    output logic [DATA_W-1:0]            s_writedata,
    output logic [DATA_W/8-1:0]          s_byteenable,
    input  logic                         s_waitrequest,
    input  logic [DATA_W-1:0]            s_readdata,
    input  logic                         s_readdatavalid,

    output logic [$clog2(MAX_PEND):0]    pend_count,
    output logic                         rsp_error
);

    localparam int PW = $clog2(MAX_PEND);
    localparam logic [PW:0] FULL_CNT = (PW+1)'(MAX_PEND);

    // Registered state
    logic              r_lock;
    logic              r_locked_id;
    logic              r_rr_last;
    logic [MAX_PEND-1:0] r_tag;
    logic [PW-1:0]     r_wr_ptr;
    logic [PW-1:0]     r_rd_ptr;
    logic [PW:0]       r_count;
    logic              r_rsp_error;

    // Combinational
    logic w_req0, w_req1;
    logic w_gnt_vld, w_gnt;
    logic w_g_read, w_g_write;
    logic w_empty, w_full, w_pop, w_push, w_rd_block, w_head;
    logic w_cmd, w_accept;

    assign w_req0 = m0_read | m0_write;
    assign w_req1 = m1_read | m1_write;

    always_comb begin
        w_gnt_vld = 1'b0;
        w_gnt     = 1'b0;
        if (r_lock) begin
            w_gnt_vld = 1'b1;
            w_gnt     = r_locked_id;
        end else if (w_req0 && w_req1) begin
            w_gnt_vld = 1'b1;
            w_gnt     = ~r_rr_last;
        end else if (w_req0) begin
            w_gnt_vld = 1'b1;
            w_gnt     = 1'b0;
        end else if (w_req1) begin
            w_gnt_vld = 1'b1;
            w_gnt     = 1'b1;
        end
    end

    assign w_g_read  = w_gnt_vld & (w_gnt ? m1_read  : m0_read);
    assign w_g_write = w_gnt_vld & (w_gnt ? m1_write : m0_write);

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == FULL_CNT);
    assign w_head  = r_tag[r_rd_ptr];
    assign w_pop   = s_readdatavalid & ~w_empty & ~reset_reset;

    // A pop in the same cycle frees a slot, so a full FIFO only blocks a
    // read when no response is being retired alongside it.
    assign w_rd_block = w_g_read & w_full & ~w_pop;

    assign s_read       = w_g_read & ~w_rd_block & ~reset_reset;
    assign s_write      = w_g_write & ~reset_reset;
    assign s_address    = w_gnt ? m1_address    : m0_address;
    assign s_writedata  = w_gnt ? m1_writedata  : m0_writedata;
    assign s_byteenable = w_gnt ? m1_byteenable : m0_byteenable;

    assign w_cmd    = s_read | s_write;
    assign w_accept = w_cmd & ~s_waitrequest;
    assign w_push   = w_accept & s_read;

    assign m0_waitrequest = reset_reset | ~(w_gnt_vld & ~w_gnt) | s_waitrequest | w_rd_block;
    assign m1_waitrequest = reset_reset | ~(w_gnt_vld &  w_gnt) | s_waitrequest | w_rd_block;

    assign m0_readdata      = s_readdata;
    assign m1_readdata      = s_readdata;
    assign m0_readdatavalid = w_pop & ~w_head;
    assign m1_readdatavalid = w_pop &  w_head;

    assign pend_count = r_count;
    assign rsp_error  = r_rsp_error;

    // Lock / round-robin state
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            r_lock      <= 1'b0;
            r_locked_id <= 1'b0;
            r_rr_last   <= 1'b1;   // m0 wins the first tie
        end else if (w_accept) begin
            r_rr_last <= w_gnt;
            r_lock    <= 1'b0;
        end else if (w_cmd) begin
            // Stalled by the controller: pin the command to this master.
            r_lock      <= 1'b1;
            r_locked_id <= w_gnt;
        end else begin
            // No command presented (idle or read-blocked). A locked master
            // that withdrew its command must not keep the other one out.
            r_lock <= 1'b0;
        end
    end

    // Tag FIFO of outstanding reads
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            r_tag    <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_tag[r_wr_ptr] <= w_gnt;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Sticky error: response with nothing outstanding
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            r_rsp_error <= 1'b0;
        end else if (s_readdatavalid && w_empty) begin
            r_rsp_error <= 1'b1;
        end
    end

endmodule

// File: tb/tb_sdram_arbiter.sv
module tb_sdram_arbiter;

    localparam int ADDR_W   = 24;
    localparam int DATA_W   = 16;
    localparam int MAX_PEND = 8;

    logic              clk_clk = 1'b0;
    logic              reset_reset;
    logic [ADDR_W-1:0] m0_address, m1_address;
    logic              m0_read, m0_write, m1_read, m1_write;
    logic [DATA_W-1:0] m0_writedata, m1_writedata;
    logic [1:0]        m0_byteenable, m1_byteenable;
    logic              m0_waitrequest, m1_waitrequest;
    logic [DATA_W-1:0] m0_readdata, m1_readdata;
    logic              m0_readdatavalid, m1_readdatavalid;
    logic [ADDR_W-1:0] s_address;
    logic              s_read, s_write;
    logic [DATA_W-1:0] s_writedata;
    logic [1:0]        s_byteenable;
    logic              s_waitrequest;
    logic [DATA_W-1:0] s_readdata;
    logic              s_readdatavalid;
    logic [3:0]        pend_count;
    logic              rsp_error;

    int total = 0;
    int bad   = 0;

    // clock
    always #5 clk_clk = ~clk_clk;

    sdram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_PEND(MAX_PEND)) dut (
        .clk_clk(clk_clk), .reset_reset(reset_reset),
        .m0_address(m0_address), .m0_read(m0_read), .m0_write(m0_write),
        .m0_writedata(m0_writedata), .m0_byteenable(m0_byteenable),
        .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata),
        .m0_readdatavalid(m0_readdatavalid),
        .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write),
        .m1_writedata(m1_writedata), .m1_byteenable(m1_byteenable),
        .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata),
        .m1_readdatavalid(m1_readdatavalid),
        .s_address(s_address), .s_read(s_read), .s_write(s_write),
        .s_writedata(s_writedata), .s_byteenable(s_byteenable),
        .s_waitrequest(s_waitrequest), .s_readdata(s_readdata),
        .s_readdatavalid(s_readdatavalid),
        .pend_count(pend_count), .rsp_error(rsp_error)
    );

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk_clk);
        #1;
    endtask

    // Let combinational outputs settle after an input change.
    task automatic settle();
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    localparam logic [23:0] A0 = 24'h0000A0;
    localparam logic [23:0] A1 = 24'h0000A1;

    initial begin
        // defaults
        reset_reset = 1'b1;
        m0_address = A0; m1_address = A1;
        m0_read = 1'b1; m1_read = 1'b1; m0_write = 1'b0; m1_write = 1'b0;
        m0_writedata = 16'h0100; m1_writedata = 16'h0200;
        m0_byteenable = 2'b11; m1_byteenable = 2'b01;
        s_waitrequest = 1'b0; s_readdata = '0; s_readdatavalid = 1'b0;

        // ---- reset held 2 cycles with both masters reading
        tick(); tick();
        chk("rst_s_read", s_read, 1'b0);
        chk("rst_m0_wait", m0_waitrequest, 1'b1);
        chk("rst_m1_wait", m1_waitrequest, 1'b1);
        chk("rst_pend", pend_count, 4'd0);
        chk("rst_rsp_err", rsp_error, 1'b0);

        // ---- release; both writing continuously, m0 first then alternation
        reset_reset = 1'b0;
        m0_read = 1'b0; m1_read = 1'b0; m0_write = 1'b1; m1_write = 1'b1;
        settle();
        for (int i = 0; i < 5; i++) begin
            chk("alt_s_write", s_write, 1'b1);
            chk("alt_addr", s_address, (i % 2 == 0) ? A0 : A1);
            chk("alt_m0_wait", m0_waitrequest, (i % 2 == 0) ? 1'b0 : 1'b1);
            chk("alt_m1_wait", m1_waitrequest, (i % 2 == 0) ? 1'b1 : 1'b0);
            chk("alt_wdata", s_writedata, (i % 2 == 0) ? 16'h0100 : 16'h0200);
            tick();
        end
        chk("alt_pend", pend_count, 4'd0);
        // last accepted was m0 (i=4)

        // ---- lock: m1 write to 0x000123 stalled for 4 cycles
        m0_write = 1'b0;
        m1_address = 24'h000123;
        s_waitrequest = 1'b1;
        settle();
        chk("lock_addr_c0", s_address, 24'h000123);
        chk("lock_m1_wait_c0", m1_waitrequest, 1'b1);
        tick();
        m0_write = 1'b1; m0_address = 24'h000456;
        settle();
        for (int i = 1; i < 4; i++) begin
            chk("lock_addr", s_address, 24'h000123);
            chk("lock_s_write", s_write, 1'b1);
            chk("lock_m0_wait", m0_waitrequest, 1'b1);
            tick();
        end
        s_waitrequest = 1'b0;
        settle();
        chk("lock_acc_addr", s_address, 24'h000123);
        chk("lock_acc_m1_wait", m1_waitrequest, 1'b0);
        chk("lock_acc_m0_wait", m0_waitrequest, 1'b1);
        tick();
        m1_write = 1'b0;
        settle();
        chk("after_lock_addr", s_address, 24'h000456);
        chk("after_lock_m0_wait", m0_waitrequest, 1'b0);
        tick();

        // ---- fill tag FIFO with 8 m0 reads
        m0_write = 1'b0; m0_read = 1'b1; m0_address = 24'h000010;
        for (int i = 0; i < 8; i++) begin
            settle();
            chk("fill_s_read", s_read, 1'b1);
            tick();
        end
        chk("full_pend", pend_count, 4'd8);
        settle();
        chk("blk_s_read", s_read, 1'b0);
        chk("blk_m0_wait", m0_waitrequest, 1'b1);
        tick();
        chk("blk_pend", pend_count, 4'd8);
        // m1 write proceeds while m0 is read-blocked
        m1_write = 1'b1; m1_address = 24'h000789;
        settle();
        chk("blk_m1_addr", s_address, 24'h000789);
        chk("blk_m1_s_write", s_write, 1'b1);
        chk("blk_m1_wait", m1_waitrequest, 1'b0);
        tick();
        m1_write = 1'b0;
        settle();
        chk("blk2_m0_wait", m0_waitrequest, 1'b1);
        // response + m0 read in the same cycle: read goes through
        s_readdatavalid = 1'b1; s_readdata = 16'h1111;
        settle();
        chk("pp_s_read", s_read, 1'b1);
        chk("pp_m0_wait", m0_waitrequest, 1'b0);
        chk("pp_m0_rdv", m0_readdatavalid, 1'b1);
        chk("pp_m1_rdv", m1_readdatavalid, 1'b0);
        chk("pp_data", m0_readdata, 16'h1111);
        tick();
        chk("pp_pend", pend_count, 4'd8);
        // drain
        m0_read = 1'b0;
        for (int i = 0; i < 8; i++) begin
            s_readdata = 16'(16'h2000 + i);
            settle();
            chk("drain_m0_rdv", m0_readdatavalid, 1'b1);
            chk("drain_data", m0_readdata, 16'h2000 + i);
            tick();
        end
        s_readdatavalid = 1'b0;
        chk("drain_pend", pend_count, 4'd0);

        // ---- interleaved reads m0, m1, m1, m0
        m0_read = 1'b1; tick(); m0_read = 1'b0;
        m1_read = 1'b1; tick(); tick(); m1_read = 1'b0;
        m0_read = 1'b1; tick(); m0_read = 1'b0;
        chk("il_pend", pend_count, 4'd4);
        s_readdatavalid = 1'b1;
        s_readdata = 16'hAAAA; settle();
        chk("il_a_m0", m0_readdatavalid, 1'b1);
        chk("il_a_m1", m1_readdatavalid, 1'b0);
        chk("il_a_data", m0_readdata, 16'hAAAA);
        tick();
        s_readdata = 16'hBBBB; settle();
        chk("il_b_m0", m0_readdatavalid, 1'b0);
        chk("il_b_m1", m1_readdatavalid, 1'b1);
        chk("il_b_data", m1_readdata, 16'hBBBB);
        tick();
        s_readdata = 16'hCCCC; settle();
        chk("il_c_m0", m0_readdatavalid, 1'b0);
        chk("il_c_m1", m1_readdatavalid, 1'b1);
        chk("il_c_data", m1_readdata, 16'hCCCC);
        tick();
        s_readdata = 16'hDDDD; settle();
        chk("il_d_m0", m0_readdatavalid, 1'b1);
        chk("il_d_m1", m1_readdatavalid, 1'b0);
        chk("il_d_data", m0_readdata, 16'hDDDD);
        tick();
        s_readdatavalid = 1'b0;
        chk("il_pend_end", pend_count, 4'd0);
        chk("il_no_err", rsp_error, 1'b0);

        // ---- stray response with empty FIFO
        s_readdatavalid = 1'b1; s_readdata = 16'hEEEE;
        settle();
        chk("err_m0_rdv", m0_readdatavalid, 1'b0);
        chk("err_m1_rdv", m1_readdatavalid, 1'b0);
        tick();
        s_readdatavalid = 1'b0;
        chk("err_set", rsp_error, 1'b1);
        chk("err_pend", pend_count, 4'd0);
        tick(); tick();
        chk("err_sticky", rsp_error, 1'b1);
        reset_reset = 1'b1;
        tick();
        chk("err_cleared", rsp_error, 1'b0);
        reset_reset = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
